// File: rtl/load_buffer.sv
// In-order load buffer between the ACU and the shared data-memory port.
// Handles one outstanding read at a time and aligns/extends the returned data for CDB writeback.
module load_buffer #(
  parameter int LB_DEPTH  = 4,
  parameter int ROB_IDX_W = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         acu_valid,
  input  logic [31:0]                  acu_addr,
  input  logic [1:0]                   acu_size,
  input  logic                         acu_unsigned,
  input  logic [ROB_IDX_W-1:0]         acu_rob_tag,
  output logic                         lb_full,
  output logic [$clog2(LB_DEPTH):0]    lb_count,
  input  logic                         lb_exec_stall,
  output logic                         proc2mem_rd,
  output logic [31:0]                  proc2mem_addr,
  input  logic [3:0]                   mem2proc_response,
  input  logic [3:0]                   mem2proc_tag,
  input  logic [63:0]                  mem2proc_data,
  output logic                         lb_wb_valid,
  output logic [31:0]                  lb_wb_data,
  output logic [ROB_IDX_W-1:0]         lb_wb_rob_tag,
  input  logic                         lb_wr_enable,
  output logic [1:0]                   lb_state
);

  localparam int PTR_W = $clog2(LB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [31:0]          addr;
    logic [1:0]           size;
    logic                 uns;
    logic [ROB_IDX_W-1:0] rob;
  } entry_t;

  entry_t [LB_DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic [3:0]            mtag_q, mtag_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [ROB_IDX_W-1:0]  wb_rob_q, wb_rob_d;

  entry_t      head_ent;
  logic        enq, pop, mem_rd;
  logic [63:0] shifted;
  logic [31:0] ext_val;

  assign head_ent = ent_q[head_q];

  // Shift the doubleword so the addressed byte lands at bit 0, then extend by size.
  always_comb begin
    shifted = mem2proc_data >> {head_ent.addr[2:0], 3'b000};
    case (head_ent.size)
      2'd0:    ext_val = head_ent.uns ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    ext_val = head_ent.uns ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: ext_val = shifted[31:0];
    endcase
  end

  always_comb begin
    ent_d     = ent_q;
    head_d    = head_q;
    tail_d    = tail_q;
    state_d   = state_q;
    mtag_d    = mtag_q;
    wb_data_d = wb_data_q;
    wb_rob_d  = wb_rob_q;
    mem_rd    = (state_q == IDLE) && (count_q != '0) && !lb_exec_stall;
    enq       = acu_valid && !lb_full;
    pop       = (state_q == DONE) && lb_wr_enable;

    case (state_q)
      IDLE: if (mem_rd && mem2proc_response != 4'd0) begin
        mtag_d  = mem2proc_response;
        state_d = WAIT;
      end
      WAIT: if (mem2proc_tag == mtag_q && mem2proc_tag != 4'd0) begin
        wb_data_d = ext_val;
        wb_rob_d  = head_ent.rob;
        state_d   = DONE;
      end
      DONE: if (lb_wr_enable) begin
        head_d  = head_q + 1'b1;
        mtag_d  = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enq) begin
      ent_d[tail_q] = '{addr: acu_addr, size: acu_size, uns: acu_unsigned, rob: acu_rob_tag};
      tail_d        = tail_q + 1'b1;
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(pop);

    // Flush wins over everything; a clear latched tag drops the in-flight response.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = IDLE;
      mtag_d  = 4'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      mtag_q    <= 4'd0;
      wb_data_q <= '0;
      wb_rob_q  <= '0;
    end else begin
      ent_q     <= ent_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
      mtag_q    <= mtag_d;
      wb_data_q <= wb_data_d;
      wb_rob_q  <= wb_rob_d;
    end
  end

  assign lb_full       = (count_q == CNT_W'(LB_DEPTH));
  assign lb_count      = count_q;
  assign proc2mem_rd   = mem_rd;
  assign proc2mem_addr = {head_ent.addr[31:3], 3'b000};
  assign lb_wb_valid   = (state_q == DONE);
  assign lb_wb_data    = wb_data_q;
  assign lb_wb_rob_tag = wb_rob_q;
  assign lb_state      = state_q;

endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: a scoreboard of expected writebacks is filled at
// enqueue time and drained as each load completes; a small responder plays the memory.
module tb_load_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        acu_valid = 1'b0;
  logic [31:0] acu_addr = '0;
  logic [1:0]  acu_size = '0;
  logic        acu_unsigned = 1'b0;
  logic [4:0]  acu_rob_tag = '0;
  logic        lb_full;
  logic [2:0]  lb_count;
  logic        lb_exec_stall = 1'b0;
  logic        proc2mem_rd;
  logic [31:0] proc2mem_addr;
  logic [3:0]  mem2proc_response = '0;
  logic [3:0]  mem2proc_tag = '0;
  logic [63:0] mem2proc_data = '0;
  logic        lb_wb_valid;
  logic [31:0] lb_wb_data;
  logic [4:0]  lb_wb_rob_tag;
  logic        lb_wr_enable = 1'b0;
  logic [1:0]  lb_state;

  load_buffer #(.LB_DEPTH(4), .ROB_IDX_W(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .acu_valid(acu_valid), .acu_addr(acu_addr), .acu_size(acu_size),
    .acu_unsigned(acu_unsigned), .acu_rob_tag(acu_rob_tag),
    .lb_full(lb_full), .lb_count(lb_count), .lb_exec_stall(lb_exec_stall),
    .proc2mem_rd(proc2mem_rd), .proc2mem_addr(proc2mem_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data), .lb_wb_valid(lb_wb_valid),
    .lb_wb_data(lb_wb_data), .lb_wb_rob_tag(lb_wb_rob_tag),
    .lb_wr_enable(lb_wr_enable), .lb_state(lb_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [36:0] exp_q[$];   // {rob_tag, data}
  logic [31:0] addr_q[$];  // expected proc2mem_addr per load
  logic [63:0] mem_q[$];   // doubleword the memory returns per load

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [63:0] d, input logic [31:0] a,
                                        input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    int          off;
    off = int'(a[2:0]);
    b = d[8*off +: 8];
    h = d[8*off +: 16];
    if (sz == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return d[8*off +: 32];
  endfunction

  // Call at a falling edge; returns at the falling edge after the load is taken.
  task automatic enqueue(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic [4:0] rob, input logic [63:0] d);
    acu_valid = 1'b1; acu_addr = a; acu_size = sz; acu_unsigned = uns; acu_rob_tag = rob;
    exp_q.push_back({rob, model(d, a, sz, uns)});
    addr_q.push_back({a[31:3], 3'b000});
    mem_q.push_back(d);
    @(negedge clock);
    acu_valid = 1'b0;
  endtask

  // Accept the head request (after 'rejects' refused cycles), return data, check, then grant.
  task automatic serve(input logic [3:0] rtag, input int rejects, input int hold);
    logic [36:0] e;
    logic [31:0] a;
    bit          seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock); #1;
      seen = proc2mem_rd;
    end
    check("rd_seen", {63'b0, seen}, 64'd1);
    a = addr_q.pop_front();
    for (int r = 0; r < rejects; r++) begin
      check("retry_addr", {32'b0, proc2mem_addr}, {32'b0, a});
      check("retry_rd", {63'b0, proc2mem_rd}, 64'd1);
      @(negedge clock); #1;
    end
    check("rd_addr", {32'b0, proc2mem_addr}, {32'b0, a});
    mem2proc_response = rtag;
    @(negedge clock);
    mem2proc_response = 4'd0;
    mem2proc_tag = (rtag == 4'd1) ? 4'd2 : 4'd1;  // foreign tag must be ignored
    mem2proc_data = '1;
    #1 check("wait_rd_low", {63'b0, proc2mem_rd}, 64'd0);
    @(negedge clock);
    #1 check("foreign_tag", {63'b0, lb_wb_valid}, 64'd0);
    mem2proc_tag = rtag;
    mem2proc_data = mem_q.pop_front();
    @(negedge clock);
    mem2proc_tag = 4'd0;
    mem2proc_data = '0;
    #1;
    e = exp_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      check("wb_valid", {63'b0, lb_wb_valid}, 64'd1);
      check("wb_data", {32'b0, lb_wb_data}, {32'b0, e[31:0]});
      check("wb_rob", {59'b0, lb_wb_rob_tag}, {59'b0, e[36:32]});
      if (h < hold) begin
        @(negedge clock); #1;
      end
    end
    lb_wr_enable = 1'b1;
    @(negedge clock);
    lb_wr_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    bit          seen;

    #1;
    check("rst_count", {61'b0, lb_count}, 64'd0);
    check("rst_full", {63'b0, lb_full}, 64'd0);
    check("rst_rd", {63'b0, proc2mem_rd}, 64'd0);
    check("rst_addr", {32'b0, proc2mem_addr}, 64'd0);
    check("rst_wb_valid", {63'b0, lb_wb_valid}, 64'd0);
    check("rst_wb_data", {32'b0, lb_wb_data}, 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Signed byte load at offset 3.
    enqueue(32'h103, 2'd0, 1'b0, 5'd7, 64'h0000_0000_8000_0000);
    check("model_byte", {32'b0, exp_q[0][31:0]}, 64'hFFFF_FF80);
    serve(4'd3, 0, 0);
    #1 check("t1_count", {61'b0, lb_count}, 64'd0);

    // Fill to capacity, reject a fifth, then keep the FIFO busy through wrap-around.
    for (int i = 0; i < 4; i++)
      enqueue(32'h1000 + 32'(i * 8), 2'd2, 1'b0, 5'(10 + i), {$urandom, $urandom});
    #1;
    check("fill_full", {63'b0, lb_full}, 64'd1);
    check("fill_count", {61'b0, lb_count}, 64'd4);
    acu_valid = 1'b1; acu_addr = 32'hDEAD_0000; acu_rob_tag = 5'd31;
    @(negedge clock);
    acu_valid = 1'b0;
    #1 check("full_ignore", {61'b0, lb_count}, 64'd4);
    serve(4'($urandom_range(1, 15)), 0, 0);
    #1 check("after_pop_full", {63'b0, lb_full}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      sz = 2'($urandom_range(0, 2));
      a = $urandom & 32'hFFFF_FFF8;
      if (sz == 2'd0) a[2:0] = 3'($urandom_range(0, 7));
      else if (sz == 2'd1) a[2:0] = {2'($urandom_range(0, 3)), 1'b0};
      else a[2:0] = {1'($urandom_range(0, 1)), 2'b00};
      if (lb_count == 3'd4) serve(4'($urandom_range(1, 15)), 0, 0);
      enqueue(a, sz, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom});
    end
    while (exp_q.size() > 0) serve(4'($urandom_range(1, 15)), 0, 0);
    #1 check("wrap_drained", {61'b0, lb_count}, 64'd0);

    // Stall holds the port; refused responses retry with the same address.
    @(negedge clock);
    lb_exec_stall = 1'b1;
    enqueue(32'h0000_3344, 2'd2, 1'b0, 5'd3, 64'h1122_3344_5566_7788);
    for (int i = 0; i < 5; i++) begin
      #1 check("stall_rd", {63'b0, proc2mem_rd}, 64'd0);
      @(negedge clock);
    end
    lb_exec_stall = 1'b0;
    #1;
    check("unstall_rd", {63'b0, proc2mem_rd}, 64'd1);
    check("unstall_addr", {32'b0, proc2mem_addr}, 64'h3340);
    serve(4'd5, 2, 0);

    // Flush while waiting, with an ACU load in the same cycle; late response is dropped.
    enqueue(32'h0000_0500, 2'd2, 1'b0, 5'd9, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock); #1;
      seen = proc2mem_rd;
    end
    check("flush_rd_seen", {63'b0, seen}, 64'd1);
    mem2proc_response = 4'd2;
    @(negedge clock);
    mem2proc_response = 4'd0;
    flush = 1'b1;
    acu_valid = 1'b1; acu_addr = 32'h0000_0600; acu_rob_tag = 5'd4;
    @(negedge clock);
    flush = 1'b0;
    acu_valid = 1'b0;
    mem2proc_tag = 4'd2;
    mem2proc_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 check("flush_count", {61'b0, lb_count}, 64'd0);
    @(negedge clock);
    mem2proc_tag = 4'd0;
    mem2proc_data = '0;
    #1;
    check("flush_no_wb", {63'b0, lb_wb_valid}, 64'd0);
    check("flush_count2", {61'b0, lb_count}, 64'd0);
    void'(exp_q.pop_front());
    void'(addr_q.pop_front());
    void'(mem_q.pop_front());
    @(negedge clock);
    enqueue(32'h0000_0704, 2'd2, 1'b0, 5'd21, 64'h8765_4321_0000_0000);
    serve(4'd2, 0, 0);

    // Unsigned half at offset 6, held in DONE for three cycles without grant.
    enqueue(32'h206, 2'd1, 1'b1, 5'd12, 64'hBEEF_0000_0000_0000);
    check("model_half", {32'b0, exp_q[0][31:0]}, 64'h0000_BEEF);
    serve(4'd9, 0, 3);
    #1;
    check("end_count", {61'b0, lb_count}, 64'd0);
    check("end_wb_valid", {63'b0, lb_wb_valid}, 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_buffer.md
Name: load_buffer

Overview:
- In-order FIFO of address-resolved loads between the address calculation unit (ACU) and the shared data-memory port.
- Issues one memory read at a time, holds one outstanding request, and aligns and extends the returned data.
- Presents the result for CDB writeback under the hazard unit's grant.
- Produces `lb_full` for the hazard unit and obeys its `lb_exec_stall` / `lb_wr_enable` controls.

Parameters:
- LB_DEPTH, 4, number of load entries (power of two, >=2)
- ROB_IDX_W, 5, width of ROB tag carried per load

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  branch mispredict; discard all loads
- acu_valid  in  1  ACU presents a resolved load this cycle
- acu_addr  in  32  byte address
- acu_size  in  2  0=byte, 1=half, 2=word
- acu_unsigned  in  1  1=zero-extend, 0=sign-extend
- acu_rob_tag  in  ROB_IDX_W  destination ROB entry
- lb_full  out  1  count==LB_DEPTH
- lb_count  out  $clog2(LB_DEPTH)+1  occupied entries
- lb_exec_stall  in  1  memory port reserved elsewhere; no new request
- proc2mem_rd  out  1  read request valid
- proc2mem_addr  out  32  {head addr[31:3], 3'b000}
- mem2proc_response  in  4  nonzero = request accepted, value is its tag
- mem2proc_tag  in  4  tag of data returning this cycle (0 = none)
- mem2proc_data  in  64  returned doubleword
- lb_wb_valid  out  1  head load complete, data ready
- lb_wb_data  out  32  aligned, extended load value
- lb_wb_rob_tag  out  ROB_IDX_W  ROB tag of the completed load
- lb_wr_enable  in  1  CDB grant; completed load retires from buffer this cycle

Behaviour:
- Reset (async):
  - FIFO empty: head=tail=count=0.
  - State IDLE, latched tag=0.
  - All outputs 0.
- Enqueue:
  - Occurs when acu_valid & ~lb_full; writes the tail entry, tail++ (wraps modulo LB_DEPTH), count++.
  - acu_valid while full is ignored; no entry is written.
  - Enqueue and pop in the same cycle leave count unchanged.
  - Full blocks enqueue even if a pop occurs in the same cycle.
- FSM on head entry:
  - IDLE: if count!=0 & ~lb_exec_stall, drive proc2mem_rd=1 with the head address in the same cycle (combinational).
    - mem2proc_response!=0: latch the tag, go to WAIT.
    - mem2proc_response==0: stay IDLE and retry the next eligible cycle.
    - proc2mem_rd=0 whenever lb_exec_stall=1.
  - WAIT: proc2mem_rd=0.
    - When mem2proc_tag==latched tag and mem2proc_tag!=0: capture data and go to DONE.
    - A response may arrive in the cycle immediately after acceptance.
    - Responses with other tags are ignored.
  - DONE: lb_wb_valid=1, with lb_wb_data and lb_wb_rob_tag registered.
    - lb_wr_enable=1: pop head (head++, count--), clear latched tag, go to IDLE. The next request may issue on the following cycle.
    - lb_wr_enable=0: hold all outputs stable.
- Data extraction (registered when captured):
  - off=addr[2:0].
  - Byte: data[8*off +: 8].
  - Half: data[8*off +: 16]; off assumed even.
  - Word: data[8*off +: 32]; off assumed 0 or 4.
  - Result is extended to 32 bits per acu_unsigned.
- Flush (synchronous, highest priority over enqueue, pop and capture):
  - Next cycle: count=0, head=tail=0, state IDLE, latched tag=0, lb_wb_valid=0.
  - A response for the flushed request is dropped because the latched tag is 0.
  - A flush in the same cycle as acu_valid does not enqueue.
- Reset mid-WAIT: same as flush, but asynchronous.
- Wrap-around: pointers wrap without losing order. Verify with more than LB_DEPTH loads in sequence.

Test Plan:
- Reset, enqueue 1 byte load addr=0x103, unsigned=0, tag=7; accept with response=3; return tag=3, data byte3=0x80 -> proc2mem_addr=0x100, lb_wb_valid=1, lb_wb_data=0xFFFFFF80, lb_wb_rob_tag=7; grant -> count=0.
- Enqueue 4 loads -> lb_full=1, lb_count=4; 5th acu_valid ignored. After 1 grant, lb_full=0. Then 6 more loads complete in FIFO order (wrap-around).
- Hold lb_exec_stall=1 for 5 cycles with 1 entry -> proc2mem_rd=0 throughout. Release -> proc2mem_rd=1 in the same cycle.
- mem2proc_response=0 for 2 cycles -> proc2mem_rd reasserted each cycle with the same address; response=5 -> WAIT.
- In WAIT with tag=2, flush; return tag=2 next cycle -> no lb_wb_valid, count=0. Next load then completes normally.
- DONE with lb_wr_enable=0 for 3 cycles -> outputs stable. Half load addr=0x206, unsigned=1, data[63:48]=0xBEEF -> lb_wb_data=0x0000BEEF.
